bsg_murn_converter_buffered: RTL and testbench

Parametrised successor to the single-slot FSB<->MURN adapter. It bridges nodes_p comm-link FSB ports to MURN block ports, and gives every node an independent els_p-deep FIFO in each direction. It adds a synchronous per-node flush, per-node saturating retry/stall statistics, and a selectable MURN retry timing mode. It sits between bsg_comm_link core-side node ports and the accelerator tile array, in the core clock domain.

---
 rtl/bsg_murn_converter_buffered.sv | 172 +++++++++++++++++
 tb/tb_bsg_murn_converter_buffered.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_murn_converter_buffered.sv
// FSB<->MURN bridge with independent per-node FIFOs in each direction, per-node flush,
// saturating retry/stall statistics and an optional one-cycle-late retry protocol.
module bsg_murn_converter_buffered #(
   parameter int nodes_p      = 4,
   parameter int ring_width_p = 80,
   parameter int els_p        = 4,
   parameter int late_retry_p = 0,
   parameter int ctr_width_p  = 16
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [nodes_p-1:0]                node_flush_i,
   input  logic                              clear_stats_i,
   input  logic [nodes_p-1:0]                v_i,
   input  logic [nodes_p*ring_width_p-1:0]   data_i,
   output logic [nodes_p-1:0]                ready_o,
   output logic [nodes_p-1:0]                switch_2_blockValid_o,
   output logic [nodes_p*ring_width_p-1:0]   switch_2_blockData_o,
   input  logic [nodes_p-1:0]                switch_2_blockRetry_i,
   input  logic [nodes_p-1:0]                block_2_switchValid_i,
   input  logic [nodes_p*ring_width_p-1:0]   block_2_switchData_i,
   output logic [nodes_p-1:0]                block_2_switchRetry_o,
   output logic [nodes_p-1:0]                v_o,
   output logic [nodes_p*ring_width_p-1:0]   data_o,
   input  logic [nodes_p-1:0]                yumi_i,
   output logic [nodes_p*ctr_width_p-1:0]    retry_cnt_o,
   output logic [nodes_p*ctr_width_p-1:0]    stall_cnt_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p) + 1;

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT} state_e;

   for (genvar n = 0; n < nodes_p; n++) begin : g_node
      logic [ring_width_p-1:0] mem_a_q [els_p];
      logic [ring_width_p-1:0] mem_b_q [els_p];
      logic [ptr_w_lp-1:0]     wp_a_q, wp_a_d, rp_a_q, rp_a_d;
      logic [ptr_w_lp-1:0]     wp_b_q, wp_b_d, rp_b_q, rp_b_d;
      logic [cnt_w_lp-1:0]     cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
      logic [ctr_width_p-1:0]  rcnt_q, rcnt_d, scnt_q, scnt_d;
      state_e                  st_q, st_d;
      logic                    flush, full_a, empty_a, full_b, empty_b;
      logic                    enq_a, deq_a, enq_b, deq_b, rej, stall;
      logic                    ready_l, sbv_l, bretry_l, vo_l;

      always_comb begin
         flush   = node_flush_i[n];
         full_a  = (cnt_a_q == cnt_w_lp'(els_p));
         empty_a = (cnt_a_q == '0);
         full_b  = (cnt_b_q == cnt_w_lp'(els_p));
         empty_b = (cnt_b_q == '0);

         ready_l = ~full_a & ~flush;
         enq_a   = v_i[n] & ready_l;

         st_d  = S_IDLE;
         sbv_l = 1'b0;
         deq_a = 1'b0;
         rej   = 1'b0;
         if (late_retry_p == 0) begin
            sbv_l = ~empty_a & ~flush;
            deq_a = sbv_l & ~switch_2_blockRetry_i[n];
            rej   = sbv_l & switch_2_blockRetry_i[n];
         end else begin
            // Retry for an offer arrives during the following WAIT cycle.
            case (st_q)
               S_IDLE, S_OFFER: begin
                  if (!empty_a) begin
                     sbv_l = 1'b1;
                     st_d  = S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (switch_2_blockRetry_i[n]) begin
                     rej  = 1'b1;
                     st_d = S_OFFER;
                  end else begin
                     deq_a = 1'b1;
                     st_d  = ((cnt_a_q > cnt_w_lp'(1)) || enq_a) ? S_OFFER : S_IDLE;
                  end
               end
               default: st_d = S_IDLE;
            endcase
            if (flush) begin
               sbv_l = 1'b0;
               deq_a = 1'b0;
               rej   = 1'b0;
               st_d  = S_IDLE;
            end
         end

         bretry_l = full_b | flush;
         enq_b    = block_2_switchValid_i[n] & ~bretry_l;
         vo_l     = ~empty_b & ~flush;
         deq_b    = yumi_i[n] & vo_l;
         stall    = bretry_l & block_2_switchValid_i[n];

         wp_a_d  = wp_a_q;
         rp_a_d  = rp_a_q;
         cnt_a_d = cnt_a_q;
         wp_b_d  = wp_b_q;
         rp_b_d  = rp_b_q;
         cnt_b_d = cnt_b_q;
         if (flush) begin
            wp_a_d  = '0;
            rp_a_d  = '0;
            cnt_a_d = '0;
            wp_b_d  = '0;
            rp_b_d  = '0;
            cnt_b_d = '0;
         end else begin
            if (enq_a) wp_a_d = wp_a_q + ptr_w_lp'(1);
            if (deq_a) rp_a_d = rp_a_q + ptr_w_lp'(1);
            cnt_a_d = cnt_a_q + cnt_w_lp'(enq_a) - cnt_w_lp'(deq_a);
            if (enq_b) wp_b_d = wp_b_q + ptr_w_lp'(1);
            if (deq_b) rp_b_d = rp_b_q + ptr_w_lp'(1);
            cnt_b_d = cnt_b_q + cnt_w_lp'(enq_b) - cnt_w_lp'(deq_b);
         end

         rcnt_d = rcnt_q;
         scnt_d = scnt_q;
         if (clear_stats_i) begin
            rcnt_d = '0;
            scnt_d = '0;
         end else begin
            if (rej && (rcnt_q != '1))   rcnt_d = rcnt_q + ctr_width_p'(1);
            if (stall && (scnt_q != '1)) scnt_d = scnt_q + ctr_width_p'(1);
         end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            wp_a_q  <= '0;
            rp_a_q  <= '0;
            cnt_a_q <= '0;
            wp_b_q  <= '0;
            rp_b_q  <= '0;
            cnt_b_q <= '0;
            rcnt_q  <= '0;
            scnt_q  <= '0;
            st_q    <= S_IDLE;
         end else begin
            wp_a_q  <= wp_a_d;
            rp_a_q  <= rp_a_d;
            cnt_a_q <= cnt_a_d;
            wp_b_q  <= wp_b_d;
            rp_b_q  <= rp_b_d;
            cnt_b_q <= cnt_b_d;
            rcnt_q  <= rcnt_d;
            scnt_q  <= scnt_d;
            st_q    <= st_d;
         end
      end

      // Storage carries no reset; occupancy counters alone define validity.
      always_ff @(posedge clk_i) begin
         if (enq_a) mem_a_q[wp_a_q] <= data_i[n*ring_width_p +: ring_width_p];
         if (enq_b) mem_b_q[wp_b_q] <= block_2_switchData_i[n*ring_width_p +: ring_width_p];
      end

      assign ready_o[n]                = ready_l;
      assign switch_2_blockValid_o[n]  = sbv_l;
      assign block_2_switchRetry_o[n]  = bretry_l;
      assign v_o[n]                    = vo_l;
      assign switch_2_blockData_o[n*ring_width_p +: ring_width_p] = mem_a_q[rp_a_q];
      assign data_o[n*ring_width_p +: ring_width_p]               = mem_b_q[rp_b_q];
      assign retry_cnt_o[n*ctr_width_p +: ctr_width_p]            = rcnt_q;
      assign stall_cnt_o[n*ctr_width_p +: ctr_width_p]            = scnt_q;
   end

endmodule

// File: tb/tb_bsg_murn_converter_buffered.sv
// Directed bench with per-node scoreboards: a two-node early-retry instance with 4-bit
// counters, and a one-node late-retry instance for the OFFER/WAIT protocol.
module tb_bsg_murn_converter_buffered;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   // two-node instance, early retry, 4-bit counters
   logic [1:0]  flush = '0, v_i = '0, s_retry = '0, bv = '0, yumi = '0;
   logic        clr = 1'b0;
   logic [31:0] data_i = '0, bdata = '0;
   logic [1:0]  ready_o, sbv, b_retry, v_o;
   logic [31:0] sbdata, data_o;
   logic [7:0]  retry_cnt, stall_cnt;

   bsg_murn_converter_buffered #(
      .nodes_p(2), .ring_width_p(16), .els_p(4), .late_retry_p(0), .ctr_width_p(4)
   ) dut0 (
      .clk_i(clk), .reset_n_i(rst_n), .node_flush_i(flush), .clear_stats_i(clr),
      .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
      .switch_2_blockValid_o(sbv), .switch_2_blockData_o(sbdata),
      .switch_2_blockRetry_i(s_retry), .block_2_switchValid_i(bv),
      .block_2_switchData_i(bdata), .block_2_switchRetry_o(b_retry),
      .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
      .retry_cnt_o(retry_cnt), .stall_cnt_o(stall_cnt)
   );

   // one-node instance, late retry
   logic        flush1 = 1'b0, clr1 = 1'b0, v1 = 1'b0, sr1 = 1'b0, bv1 = 1'b0, yumi1 = 1'b0;
   logic [15:0] d1 = '0, bd1 = '0;
   logic        ready1, sbv1, bretry1, vo1;
   logic [15:0] sbd1, do1, rc1, sc1;

   bsg_murn_converter_buffered #(
      .nodes_p(1), .ring_width_p(16), .els_p(4), .late_retry_p(1), .ctr_width_p(16)
   ) dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .node_flush_i(flush1), .clear_stats_i(clr1),
      .v_i(v1), .data_i(d1), .ready_o(ready1),
      .switch_2_blockValid_o(sbv1), .switch_2_blockData_o(sbd1),
      .switch_2_blockRetry_i(sr1), .block_2_switchValid_i(bv1),
      .block_2_switchData_i(bd1), .block_2_switchRetry_o(bretry1),
      .v_o(vo1), .data_o(do1), .yumi_i(yumi1),
      .retry_cnt_o(rc1), .stall_cnt_o(sc1)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] qa [2][$];
   logic [15:0] qb [2][$];
   logic        acc_a0, acc_b0;
   int          k;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Settle inputs, score the transfers of this cycle, then advance one clock.
   task automatic cyc();
      #1;
      for (int n = 0; n < 2; n++) begin
         if (sbv[n] && !s_retry[n]) begin
            if (qa[n].size() == 0) check($sformatf("a_extra%0d", n), 64'd1, 64'd0);
            else check($sformatf("a_data%0d", n), 64'(sbdata[n*16 +: 16]), 64'(qa[n].pop_front()));
         end
         if (v_o[n] && yumi[n]) begin
            if (qb[n].size() == 0) check($sformatf("b_extra%0d", n), 64'd1, 64'd0);
            else check($sformatf("b_data%0d", n), 64'(data_o[n*16 +: 16]), 64'(qb[n].pop_front()));
         end
         if (v_i[n] && ready_o[n]) qa[n].push_back(data_i[n*16 +: 16]);
         if (bv[n] && !b_retry[n]) qb[n].push_back(bdata[n*16 +: 16]);
      end
      acc_a0 = v_i[0] & ready_o[0];
      acc_b0 = bv[0] & ~b_retry[0];
      for (int n = 0; n < 2; n++) begin
         if (flush[n]) begin
            qa[n].delete();
            qb[n].delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #12;
      check("rst_ready", 64'(ready_o), 64'h3);
      check("rst_sbv", 64'(sbv), 64'h0);
      check("rst_v_o", 64'(v_o), 64'h0);
      check("rst_bretry", 64'(b_retry), 64'h0);
      check("rst_cnt", 64'({retry_cnt, stall_cnt}), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();

      // basic A-path, node 0
      v_i[0] = 1'b1; data_i[15:0] = 16'h11;
      cyc();
      check("basic_first_valid", 64'(sbv[0]), 64'd1);
      check("basic_first_data", 64'(sbdata[15:0]), 64'h11);
      check("basic_ready1", 64'(ready_o[0]), 64'd1);
      data_i[15:0] = 16'h22;
      cyc();
      check("basic_ready2", 64'(ready_o[0]), 64'd1);
      data_i[15:0] = 16'h33;
      cyc();
      check("basic_ready3", 64'(ready_o[0]), 64'd1);
      v_i = '0;
      cyc();
      cyc();
      check("basic_drained", 64'(qa[0].size()), 64'd0);
      check("basic_idle", 64'(sbv[0]), 64'd0);

      // full / backpressure
      s_retry = 2'b01; k = 0;
      for (int c = 0; c < 8; c++) begin
         v_i[0] = (k < 6); data_i[15:0] = 16'hA1 + 16'(k);
         cyc();
         if (acc_a0) k++;
      end
      check("full_ready", 64'(ready_o[0]), 64'd0);
      check("full_accepted", 64'(k), 64'd4);
      check("full_retry_cnt", 64'(retry_cnt[3:0]), 64'd7);
      s_retry = '0;
      v_i[0] = 1'b1; data_i[15:0] = 16'hA1 + 16'(k);
      cyc();
      check("full_no_enq_on_pop", 64'(acc_a0), 64'd0);
      if (acc_a0) k++;
      for (int c = 0; c < 10; c++) begin
         v_i[0] = (k < 6); data_i[15:0] = 16'hA1 + 16'(k);
         cyc();
         if (acc_a0) k++;
      end
      v_i = '0;
      check("full_all_accepted", 64'(k), 64'd6);
      check("full_drained", 64'(qa[0].size()), 64'd0);
      check("full_retry_hold", 64'(retry_cnt[3:0]), 64'd7);

      // B-path fill, stall count, drain
      k = 0;
      for (int c = 0; c < 7; c++) begin
         bv[0] = (k < 5); bdata[15:0] = 16'hB1 + 16'(k);
         cyc();
         if (acc_b0) k++;
      end
      check("b_full_retry", 64'(b_retry[0]), 64'd1);
      check("b_accepted", 64'(k), 64'd4);
      check("b_stall3", 64'(stall_cnt[3:0]), 64'd3);
      check("b_valid", 64'(v_o[0]), 64'd1);
      for (int c = 0; c < 8; c++) begin
         bv[0] = (k < 5); bdata[15:0] = 16'hB1 + 16'(k);
         yumi[0] = v_o[0];
         cyc();
         if (acc_b0) k++;
      end
      bv = '0; yumi = '0;
      check("b_stall4", 64'(stall_cnt[3:0]), 64'd4);
      check("b_drained", 64'(qb[0].size()), 64'd0);
      check("b_empty", 64'(v_o[0]), 64'd0);

      // flush isolation
      s_retry = 2'b11;
      for (int i = 0; i < 3; i++) begin
         v_i = 2'b11; bv = 2'b11;
         data_i = {16'h1100 + 16'(i), 16'h0100 + 16'(i)};
         bdata  = {16'h1B00 + 16'(i), 16'h0B00 + 16'(i)};
         cyc();
      end
      v_i = '0; bv = '0;
      flush = 2'b10;
      #1;
      check("fl_ready_low", 64'(ready_o), 64'b01);
      check("fl_sbv", 64'(sbv), 64'b01);
      check("fl_v_o", 64'(v_o), 64'b01);
      check("fl_bretry", 64'(b_retry), 64'b10);
      cyc();
      flush = '0;
      #1;
      check("fl_after_sbv", 64'(sbv), 64'b01);
      check("fl_after_v_o", 64'(v_o), 64'b01);
      check("fl_after_ready", 64'(ready_o), 64'b11);
      check("fl_retry_cnt", 64'(retry_cnt), 64'h2A);
      check("fl_stall_cnt", 64'(stall_cnt), 64'h04);
      s_retry = '0;
      for (int c = 0; c < 6; c++) begin
         yumi = v_o;
         cyc();
      end
      yumi = '0;
      check("fl_n0_a_drained", 64'(qa[0].size()), 64'd0);
      check("fl_n0_b_drained", 64'(qb[0].size()), 64'd0);

      // saturation, clear, asynchronous reset mid-stream
      s_retry = 2'b01;
      v_i[0] = 1'b1; data_i[15:0] = 16'h55;
      cyc();
      v_i = '0;
      for (int c = 0; c < 20; c++) cyc();
      check("sat_retry", 64'(retry_cnt[3:0]), 64'd15);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      check("clr_retry", 64'(retry_cnt[3:0]), 64'd0);
      check("clr_stall", 64'(stall_cnt[3:0]), 64'd0);
      bv[0] = 1'b1; bdata[15:0] = 16'h66;
      cyc();
      bv = '0;
      check("mid_sbv", 64'(sbv[0]), 64'd1);
      check("mid_v_o", 64'(v_o[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_sbv", 64'(sbv), 64'h0);
      check("arst_v_o", 64'(v_o), 64'h0);
      check("arst_ready", 64'(ready_o), 64'h3);
      check("arst_bretry", 64'(b_retry), 64'h0);
      check("arst_cnt", 64'(retry_cnt), 64'h0);
      for (int n = 0; n < 2; n++) begin
         qa[n].delete();
         qb[n].delete();
      end
      s_retry = '0;
      cyc();
      rst_n = 1'b1;
      cyc();
      check("post_rst_sbv", 64'(sbv), 64'h0);
      check("post_rst_v_o", 64'(v_o), 64'h0);

      // late retry protocol
      v1 = 1'b1; d1 = 16'hAB; sr1 = 1'b0;
      cyc();
      v1 = 1'b0;
      check("late_offer1", 64'(sbv1), 64'd1);
      check("late_data1", 64'(sbd1), 64'hAB);
      cyc();
      check("late_wait1", 64'(sbv1), 64'd0);
      sr1 = 1'b1;
      cyc();
      sr1 = 1'b0;
      check("late_reoffer", 64'(sbv1), 64'd1);
      check("late_reoffer_data", 64'(sbd1), 64'hAB);
      check("late_retry_cnt1", 64'(rc1), 64'd1);
      cyc();
      check("late_wait2", 64'(sbv1), 64'd0);
      cyc();
      check("late_popped", 64'(sbv1), 64'd0);
      check("late_retry_cnt", 64'(rc1), 64'd1);
      check("late_ready", 64'(ready1), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
